// File: rtl/regfile_2w4r.sv
// Dual-writeback, quad-read integer register file.
// Slot 1 is the older instruction and slot 2 the younger; when both retire
// to the same register the younger value is the architectural result.
// Reads are combinational with write-through bypass so that a consumer in
// the same cycle as the producer's writeback sees the new value.
// Entry 0 is hardwired to zero. A running count of effective writes is kept.
module regfile_2w4r #(
  parameter int REG_DW = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb1_en_i,
  input  logic [REG_AW-1:0] wb1_addr_i,
  input  logic [REG_DW-1:0] wb1_data_i,
  input  logic              wb2_en_i,
  input  logic [REG_AW-1:0] wb2_addr_i,
  input  logic [REG_DW-1:0] wb2_data_i,
  input  logic [REG_AW-1:0] rd1_addr_i,
  input  logic [REG_AW-1:0] rd2_addr_i,
  input  logic [REG_AW-1:0] rd3_addr_i,
  input  logic [REG_AW-1:0] rd4_addr_i,
  output logic [REG_DW-1:0] rd1_data_o,
  output logic [REG_DW-1:0] rd2_data_o,
  output logic [REG_DW-1:0] rd3_data_o,
  output logic [REG_DW-1:0] rd4_data_o,
  output logic [31:0]       wr_cnt_o
);

  localparam int NUM_REGS = 2 ** REG_AW;

  logic [REG_DW-1:0] mem_r [NUM_REGS];
  logic [31:0]       wr_cnt_r;

  logic              wb1_eff_s;
  logic              wb2_eff_s;
  logic              same_dst_s;
  logic [REG_AW-1:0] rd_addr_s [4];
  logic [REG_DW-1:0] rd_data_s [4];

  // A write only counts when enabled and not aimed at the zero register.
  assign wb1_eff_s  = wb1_en_i && (wb1_addr_i != {REG_AW{1'b0}});
  assign wb2_eff_s  = wb2_en_i && (wb2_addr_i != {REG_AW{1'b0}});
  assign same_dst_s = wb1_eff_s && wb2_eff_s && (wb1_addr_i == wb2_addr_i);

  assign rd_addr_s[0] = rd1_addr_i;
  assign rd_addr_s[1] = rd2_addr_i;
  assign rd_addr_s[2] = rd3_addr_i;
  assign rd_addr_s[3] = rd4_addr_i;

  assign rd1_data_o = rd_data_s[0];
  assign rd2_data_o = rd_data_s[1];
  assign rd3_data_o = rd_data_s[2];
  assign rd4_data_o = rd_data_s[3];
  assign wr_cnt_o   = wr_cnt_r;

  // Register storage: cleared by reset, slot 2 overrides slot 1 on a shared target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= {REG_DW{1'b0}};
      end
    end else begin
      if (wb1_eff_s && !same_dst_s) begin
        mem_r[wb1_addr_i] <= wb1_data_i;
      end
      if (wb2_eff_s) begin
        mem_r[wb2_addr_i] <= wb2_data_i;
      end
    end
  end

  // Commit counter: adds 0, 1 or 2 per cycle and wraps silently; a collision still counts 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_r <= 32'd0;
    end else begin
      wr_cnt_r <= wr_cnt_r + {31'd0, wb1_eff_s} + {31'd0, wb2_eff_s};
    end
  end

  // Read ports: zero in reset or for x0, else bypass younger then older writeback, else storage.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rd_data_s[p] = {REG_DW{1'b0}};
      if (!rst) begin
        rd_data_s[p] = {REG_DW{1'b0}};
      end else if (rd_addr_s[p] == {REG_AW{1'b0}}) begin
        rd_data_s[p] = {REG_DW{1'b0}};
      end else if (wb2_eff_s && (rd_addr_s[p] == wb2_addr_i)) begin
        rd_data_s[p] = wb2_data_i;
      end else if (wb1_eff_s && (rd_addr_s[p] == wb1_addr_i)) begin
        rd_data_s[p] = wb1_data_i;
      end else begin
        rd_data_s[p] = mem_r[rd_addr_s[p]];
      end
    end
  end

endmodule

// File: doc/regfile_2w4r.md
REGFILE_2W4R -- requirements
Module: regfile_2w4r

Interface
REQ-001 SHALL provide parameter REG_DW, default 32, meaning register data width.
REQ-002 SHALL provide parameter REG_AW, default 5, meaning register address width (2^REG_AW entries).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port wb1_en_i  input  1  slot-1 (older instruction) writeback enable.
REQ-006 SHALL provide port wb1_addr_i  input  REG_AW  slot-1 destination register.
REQ-007 SHALL provide port wb1_data_i  input  REG_DW  slot-1 writeback data.
REQ-008 SHALL provide port wb2_en_i  input  1  slot-2 (younger instruction) writeback enable.
REQ-009 SHALL provide port wb2_addr_i  input  REG_AW  slot-2 destination register.
REQ-010 SHALL provide port wb2_data_i  input  REG_DW  slot-2 writeback data.
REQ-011 SHALL provide ports rdN_addr_i  input  REG_AW  read address, N=1..4; ports 1-2 serve slot 1 rs1/rs2, ports 3-4 serve slot 2 rs1/rs2.
REQ-012 SHALL provide ports rdN_data_o  output  REG_DW  read data, N=1..4.
REQ-013 SHALL provide port wr_cnt_o  output  32  running count of committed register writes.

Function
REQ-014 SHALL hold 2^REG_AW entries of REG_DW bits; entry 0 SHALL always read 0 and never be written.
REQ-015 A port write is effective when its en is 1 and its addr is nonzero; effective writes update storage on the rising clk edge.
REQ-016 When both ports write the same nonzero address in one cycle, slot 2 data SHALL be stored (younger wins).
REQ-017 Writes to different addresses in the same cycle SHALL both be stored.
REQ-018 Reads SHALL be combinational, zero-cycle latency, from stored contents.
REQ-019 Write-through bypass: if a read address is nonzero and matches an effective slot-2 write in the current cycle, rdN_data_o SHALL equal wb2_data_i.
REQ-020 Otherwise, if it matches an effective slot-1 write, rdN_data_o SHALL equal wb1_data_i.
REQ-021 Read address 0 SHALL return 0 regardless of any write-port activity.
REQ-022 wr_cnt_o SHALL increase by the number of effective writes each cycle (0, 1 or 2; a same-address collision counts 2).
REQ-023 wr_cnt_o SHALL wrap modulo 2^32 with no saturation or flag.
REQ-024 Write enables with X/undefined address are outside contract; no protection required.

Reset
REQ-025 On rst falling, all entries and wr_cnt_o SHALL clear to 0 immediately, without waiting for clk.
REQ-026 While rst is 0, writes SHALL be ignored, bypass SHALL be suppressed, and all rdN_data_o SHALL be 0.
REQ-027 The first write accepted after reset SHALL be on the first rising clk edge sampled with rst at 1.
REQ-028 Reset asserted mid-operation SHALL discard any write of that cycle and clear state, with no partial update.

Verification
REQ-029 Write x5=0x1234 via slot 1, next cycle read port 1 addr 5 -> 0x00001234; wr_cnt_o=1.
REQ-030 Same cycle slot1 x7=0xAAAA, slot2 x7=0x5555 -> bypass reads 0x5555; after edge x7=0x5555; wr_cnt_o +2.
REQ-031 Slot1 x3=0x11, slot2 x4=0x22, all four read ports addressing 3,4,3,4 in the same cycle -> 0x11,0x22,0x11,0x22 before the edge.
REQ-032 Both ports write x0=0xFFFF_FFFF -> read x0 = 0 always; wr_cnt_o unchanged.
REQ-033 Preload wr_cnt to 0xFFFF_FFFF (via writes or force), then two effective writes -> wr_cnt_o=0x0000_0001.
REQ-034 Write x9=0xDEAD, pull rst low between clk edges -> x9 reads 0 and wr_cnt_o=0 before the next edge; write presented during reset is not stored.
